// File: rtl/spram_arbiter_pkg.sv
// rtl/spram_arbiter_pkg.sv - shared types and constants for the single-port RAM arbiter
package spram_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/spram_arbiter_rr_arb2.sv
// rtl/spram_arbiter_rr_arb2.sv - two-way round-robin grant with priority pointer
module rr_arb2
    import spram_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] valid_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    // The pointer only advances on contention, so a lone requester never steals priority.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        if (en_i) begin
            if (&valid_i) begin
                grant_o = ptr_q ? 2'b10 : 2'b01;
                ptr_d   = ~ptr_q;
            end else begin
                grant_o = valid_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-requester single-port RAM arbiter with clear-on-init sweep
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DATA_DEPTH = 1024,
    parameter  int BYTE_SIZE  = 8,
    localparam int AW         = $clog2(DATA_DEPTH),
    localparam int NB         = DATA_WIDTH / BYTE_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_i,
    output logic                          init_busy_o,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*AW-1:0]         req_addr_i,
    input  logic [NUM_REQ*NB-1:0]         req_we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    output logic [DATA_WIDTH-1:0]         resp_rdata_o,
    output logic [AW-1:0]                 ram_addr_o,
    output logic [NB-1:0]                 ram_we_o,
    output logic [DATA_WIDTH-1:0]         ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]         ram_rdata_i
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_DEPTH - 1);

    state_t                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [AW-1:0]           addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
    logic [NUM_REQ-1:0]      grant;
    logic                    run_en;
    logic                    sel;
    logic [NB-1:0]           sel_we;

    assign run_en = (state_q == RUN) && !init_i;
    assign sel    = grant[1];
    assign sel_we = req_we_i[int'(sel)*NB +: NB];

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en_i    (run_en),
        .valid_i (req_valid_i),
        .grant_o (grant)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = '0;
        ram_addr_o   = addr_q;
        ram_we_o     = '0;
        ram_wdata_o  = wdata_q;
        case (state_q)
            INIT: begin
                ram_addr_o  = cnt_q;
                ram_we_o    = '1;
                ram_wdata_o = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            RUN: begin
                if (init_i) begin
                    state_d = INIT;
                end
                if (|grant) begin
                    ram_addr_o  = req_addr_i[int'(sel)*AW +: AW];
                    ram_we_o    = sel_we;
                    ram_wdata_o = req_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                    if (sel_we == '0) begin
                        resp_valid_d = grant;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Last driven address/data are captured every cycle so idle cycles hold them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= ram_addr_o;
            wdata_q      <= ram_wdata_o;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready_o  = grant;
    assign init_busy_o  = (state_q == INIT);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = (|resp_valid_q) ? ram_rdata_i : '0;

endmodule
